// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST     = 32'h0000_0013;

  localparam int unsigned FETCH_FIFO_DEPTH = 2;
  localparam int unsigned FIFO_PTR_W       = $clog2(FETCH_FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W       = $clog2(FETCH_FIFO_DEPTH + 1);

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Request/discard control states.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT         = 2'd1,
    ST_WAIT_DISCARD = 2'd2
  } fetch_state_t;

  // Clear the byte-offset bits so an address points at a whole word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, inst} buffer between instruction memory and decode.
// Ports: clk, rst (async, active-high), clear (drop all entries),
//        push/push_data, pop, head (oldest entry), count, empty, full.
module fetch_fifo
  import if_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  fetch_entry_t          push_data,
  input  logic                  pop,
  output fetch_entry_t          head,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty,
  output logic                  full
);

  fetch_entry_t            mem [FETCH_FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0]   wr_ptr;
  logic [FIFO_PTR_W-1:0]   rd_ptr;
  logic                    do_push;
  logic                    do_pop;

  function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] p);
    return (p == FIFO_PTR_W'(FETCH_FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == FIFO_CNT_W'(FETCH_FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only accepted when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    end
  end

  // Payload storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues single-outstanding word requests to
// instruction memory, buffers responses, and presents them to decode.
// Ports: clk, rst (async, active-high); stall_i, flush_i, target_i from the
//        pipeline; imem_req_o/imem_addr_o/imem_ack_i/imem_rdata_i to memory;
//        valid_o/pc_o/inst_o toward decode.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = FETCH_FIFO_DEPTH
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o
);

  fetch_state_t            state;
  logic [XLEN-1:0]         fetch_pc;
  logic [XLEN-1:0]         pc_nx_c;
  logic [FIFO_CNT_W-1:0]   count_nx_c;
  logic                    room_c;
  logic                    push_c;
  logic                    pop_c;
  fetch_entry_t            push_data_c;
  fetch_entry_t            fifo_head;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;

  // Only a response to a live, non-discarded request enters the buffer; flush drops it.
  assign push_c      = imem_ack_i && (state == ST_WAIT) && !flush_i && !fifo_full;
  assign pop_c       = !fifo_empty && !stall_i && !flush_i;
  assign push_data_c = '{pc: fetch_pc, inst: imem_rdata_i};

  // Next fetch PC: redirect wins, otherwise advance past each accepted word.
  always_comb begin
    pc_nx_c = fetch_pc;
    if (flush_i)     pc_nx_c = word_align(target_i);
    else if (push_c) pc_nx_c = fetch_pc + XLEN'(4);
  end

  // Buffer occupancy after this edge, used to decide whether a new request fits.
  always_comb begin
    count_nx_c = fifo_count;
    if (flush_i) count_nx_c = '0;
    else         count_nx_c = fifo_count + FIFO_CNT_W'(push_c) - FIFO_CNT_W'(pop_c);
  end

  assign room_c = (count_nx_c < FIFO_CNT_W'(FIFO_DEPTH));

  // Request/discard control; a request is held until its ack arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
      fetch_pc    <= word_align(RESET_PC);
    end else begin
      fetch_pc <= pc_nx_c;
      case (state)
        ST_IDLE: begin
          if (room_c) begin
            state       <= ST_WAIT;
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc_nx_c;
          end
        end
        ST_WAIT, ST_WAIT_DISCARD: begin
          if (imem_ack_i) begin
            if (room_c) begin
              state       <= ST_WAIT;
              imem_req_o  <= 1'b1;
              imem_addr_o <= pc_nx_c;
            end else begin
              state      <= ST_IDLE;
              imem_req_o <= 1'b0;
            end
          end else if (flush_i) begin
            // Response still owed by memory; mark it to be dropped on arrival.
            state <= ST_WAIT_DISCARD;
          end
        end
        default: begin
          state      <= ST_IDLE;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_i),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (pop_c),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Decode sees the buffer head directly; an empty buffer shows a NOP at PC 0.
  assign valid_o = !fifo_empty;
  assign pc_o    = fifo_empty ? '0 : fifo_head.pc;
  assign inst_o  = fifo_empty ? NOP_INST : fifo_head.inst;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: memory model with programmable latency,
// scoreboard of expected {pc, inst}, table-driven redirect scenarios and
// hand-written stall / flush / reset sequences.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  if_fetch #(.RESET_PC(TB_RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .target_i     (target_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .valid_o      (valid_o),
    .pc_o         (pc_o),
    .inst_o       (inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory model ----------------
  int unsigned lat;
  logic        spur;
  logic        mem_pend;
  logic [31:0] mem_addr;
  int unsigned mem_wait;

  initial begin
    imem_ack_i   = 1'b0;
    imem_rdata_i = 32'h0;
    mem_pend     = 1'b0;
    mem_addr     = 32'h0;
    mem_wait     = 0;
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_pend   = 1'b0;
      imem_ack_i = 1'b0;
      mem_wait   = 0;
    end else begin
      if (imem_ack_i) begin
        imem_ack_i = 1'b0;
        mem_pend   = 1'b0;
      end
      if (imem_req_o && !mem_pend) begin
        mem_pend = 1'b1;
        mem_addr = imem_addr_o;
        mem_wait = lat;
      end
      if (mem_pend) begin
        if (mem_wait == 0) begin
          imem_ack_i   = 1'b1;
          imem_rdata_i = mem_data(mem_addr);
        end else begin
          mem_wait--;
        end
      end else if (spur) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] pop_log[$];
  logic [31:0] m_pc;
  logic        m_pend;
  logic        m_drop;
  logic [31:0] m_addr;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      pop_log.delete();
      m_pc   = TB_RESET_PC;
      m_pend = 1'b0;
      m_drop = 1'b0;
      m_addr = 32'h0;
    end else begin
      chk("valid_o", 32'(valid_o), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        chk("pc_o", pc_o, sb_q[0].pc);
        chk("inst_o", inst_o, sb_q[0].inst);
      end else begin
        chk("pc_o_empty", pc_o, 32'h0);
        chk("inst_o_empty", inst_o, NOP_INST);
      end
      if (m_pend) begin
        chk("req_held", 32'(imem_req_o), 32'd1);
        chk("addr_held", imem_addr_o, m_addr);
      end else if (imem_req_o) begin
        chk("req_addr", imem_addr_o, m_pc);
        chk("req_room", 32'(sb_q.size() < 2), 32'd1);
        m_pend = 1'b1;
        m_addr = imem_addr_o;
        m_drop = 1'b0;
      end
      if (flush_i) begin
        if (m_pend && imem_ack_i) begin
          m_pend = 1'b0;
          m_drop = 1'b0;
        end else if (m_pend) begin
          m_drop = 1'b1;
        end
        sb_q.delete();
        pop_log.delete();
        m_pc = target_i & ~32'd3;
      end else begin
        if (valid_o && !stall_i && sb_q.size() != 0) begin
          pop_log.push_back(sb_q[0].pc);
          void'(sb_q.pop_front());
        end
        if (imem_ack_i && m_pend) begin
          if (!m_drop) begin
            sb_q.push_back('{pc: m_pc, inst: mem_data(m_pc)});
            m_pc = m_pc + 32'd4;
          end
          m_pend = 1'b0;
          m_drop = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input int unsigned lat_v);
    rst      = 1'b1;
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    target_i = 32'h0;
    spur     = 1'b0;
    lat      = lat_v;
    @(posedge clk); #2;
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, NOP_INST);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, TB_RESET_PC);
  endtask

  task automatic wait_pops(input int n);
    for (int k = 0; k < 400 && pop_log.size() < n; k++) @(posedge clk);
    #1;
    chk("pops_seen", 32'(pop_log.size() >= n), 32'd1);
  endtask

  task automatic chk_pops(input string name, input logic [31:0] p0, input logic [31:0] p1);
    if (pop_log.size() >= 2) begin
      chk({name, "_pc0"}, pop_log[0], p0);
      chk({name, "_pc1"}, pop_log[1], p1);
    end
  endtask

  typedef struct {
    int unsigned lat;
    int unsigned flush_cyc;
    logic [31:0] target;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [5];

  initial begin
    rst      = 1'b1;
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    target_i = 32'h0;
    spur     = 1'b0;
    lat      = 1;

    // {latency, flush cycle after first request (0 = none), target, first three decoded PCs}
    vecs[0] = '{1, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    vecs[1] = '{3, 1, 32'h0000_0105, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
    vecs[2] = '{2, 2, 32'h0000_0300, 32'h0000_0300, 32'h0000_0304, 32'h0000_0308};
    vecs[3] = '{1, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    vecs[4] = '{4, 3, 32'h0000_0007, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};

    for (int i = 0; i < 5; i++) begin
      do_reset(vecs[i].lat);
      if (vecs[i].flush_cyc != 0) begin
        repeat (vecs[i].flush_cyc) @(posedge clk);
        #1;
        flush_i  = 1'b1;
        target_i = vecs[i].target;
        @(posedge clk); #1;
        flush_i = 1'b0;
      end
      wait_pops(3);
      if (pop_log.size() >= 3) begin
        chk($sformatf("vec%0d_pc0", i), pop_log[0], vecs[i].exp0);
        chk($sformatf("vec%0d_pc1", i), pop_log[1], vecs[i].exp1);
        chk($sformatf("vec%0d_pc2", i), pop_log[2], vecs[i].exp2);
      end
    end

    // Stall fills the buffer; a stray ack while idle must be ignored.
    do_reset(1);
    stall_i = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("stall_valid", 32'(valid_o), 32'd1);
    chk("stall_pc", pc_o, 32'h0);
    chk("stall_req", 32'(imem_req_o), 32'd0);
    #1 spur = 1'b1;
    @(posedge clk); #2;
    spur = 1'b0;
    @(posedge clk); #1;
    chk("stall_req_after_spur", 32'(imem_req_o), 32'd0);
    stall_i = 1'b0;
    wait_pops(4);
    chk_pops("stall", 32'h0, 32'h4);
    if (pop_log.size() >= 4) begin
      chk("stall_pc2", pop_log[2], 32'h8);
      chk("stall_pc3", pop_log[3], 32'hC);
    end

    // Flush coincident with ack while buffer + outstanding request are full.
    do_reset(2);
    stall_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      if (imem_ack_i && valid_o) break;
    end
    chk("ffull_setup", 32'(imem_ack_i && valid_o), 32'd1);
    flush_i  = 1'b1;
    target_i = 32'h0000_0200;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("ffull_valid", 32'(valid_o), 32'd0);
    chk("ffull_req", 32'(imem_req_o), 32'd1);
    chk("ffull_addr", imem_addr_o, 32'h0000_0200);
    stall_i = 1'b0;
    wait_pops(2);
    chk_pops("ffull", 32'h0000_0200, 32'h0000_0204);

    // Second redirect while the first discard is still pending.
    do_reset(4);
    @(posedge clk); #1;
    flush_i  = 1'b1;
    target_i = 32'h0000_0400;
    @(posedge clk); #1;
    target_i = 32'h0000_0503;
    @(posedge clk); #1;
    flush_i = 1'b0;
    wait_pops(2);
    chk_pops("dflush", 32'h0000_0500, 32'h0000_0504);

    // Asynchronous reset with a request pending and one buffered entry.
    do_reset(3);
    stall_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (valid_o && imem_req_o) break;
    end
    chk("arst_setup", 32'(valid_o && imem_req_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_inst", inst_o, NOP_INST);
    stall_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_first_req", 32'(imem_req_o), 32'd1);
    chk("arst_first_addr", imem_addr_o, TB_RESET_PC);
    wait_pops(2);
    chk_pops("arst", 32'h0, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
